// File: rtl/sd_mount_ctrl_if.sv
// rtl/sd_mount_ctrl_if.sv - mount/eject strobes, SPI chip-select/activity and LED signals for sd_mount_ctrl
interface sd_mount_ctrl_if #(
   parameter int NUM_DRIVES = 2
);
   logic [NUM_DRIVES-1:0] img_mounted;
   logic [NUM_DRIVES-1:0] img_size_nz;
   logic [NUM_DRIVES-1:0] sd_cs_n;
   logic                  sd_mosi;
   logic                  sd_miso;
   logic                  ioctl_download;
   logic                  blink_en;
   logic [NUM_DRIVES-1:0] vsd_sel;
   logic [NUM_DRIVES-1:0] ss_gated;
   logic [NUM_DRIVES-1:0] drive_active;
   logic                  reset_img;
   logic                  led_n;

   // Core / mist_io side: drives strobes and SPI lines, observes mount status.
   modport master (
      output img_mounted, img_size_nz, sd_cs_n, sd_mosi, sd_miso, ioctl_download, blink_en,
      input  vsd_sel, ss_gated, drive_active, reset_img, led_n
   );

   // Controller side.
   modport slave (
      input  img_mounted, img_size_nz, sd_cs_n, sd_mosi, sd_miso, ioctl_download, blink_en,
      output vsd_sel, ss_gated, drive_active, reset_img, led_n
   );
endinterface

// File: rtl/sd_mount_ctrl.sv
// rtl/sd_mount_ctrl.sv - per-drive virtual-SD mount tracking, core reset pulse and SPI activity LED
module sd_mount_ctrl #(
   parameter int NUM_DRIVES  = 2,
   parameter int RESET_HOLD  = 10000000,
   parameter int ACT_TIMEOUT = 1000000,
   parameter int BLINK_W     = 22
) (
   input  logic clk_sys,
   input  logic reset,
   sd_mount_ctrl_if.slave bus
);
   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam int AW = (ACT_TIMEOUT > 0) ? $clog2(ACT_TIMEOUT + 1) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD - 1);
   localparam logic [AW-1:0] ACT_MAX   = AW'(ACT_TIMEOUT);

   typedef enum logic [1:0] {EMPTY, HOLD, READY} state_t;

   state_t                state    [NUM_DRIVES];
   state_t                state_nx [NUM_DRIVES];
   logic [HW-1:0]         hold_cnt    [NUM_DRIVES];
   logic [HW-1:0]         hold_cnt_nx [NUM_DRIVES];
   logic [NUM_DRIVES-1:0] vsd_sel_r, vsd_sel_nx;
   logic                  reset_img_r, reset_img_nx;

   logic                  old_mosi, old_miso;
   logic                  spi_edge;
   logic [NUM_DRIVES-1:0] hit;
   logic [AW-1:0]         act_cnt [NUM_DRIVES];
   logic [NUM_DRIVES-1:0] active;
   logic [BLINK_W-1:0]    blink_cnt;
   logic                  led_n_r;

   // Mount FSM state, hold counters, image-present flags and the reset request.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            state[i]    <= EMPTY;
            hold_cnt[i] <= '0;
         end
         vsd_sel_r   <= '0;
         reset_img_r <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            state[i]    <= state_nx[i];
            hold_cnt[i] <= hold_cnt_nx[i];
         end
         vsd_sel_r   <= vsd_sel_nx;
         reset_img_r <= reset_img_nx;
      end
   end

   // Next state: a strobe always (re)starts HOLD; HOLD ends in READY or EMPTY by image presence.
   always_comb begin
      vsd_sel_nx = vsd_sel_r;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         state_nx[i]    = state[i];
         hold_cnt_nx[i] = hold_cnt[i];
         if (bus.img_mounted[i]) begin
            vsd_sel_nx[i]  = bus.img_size_nz[i];
            state_nx[i]    = HOLD;
            hold_cnt_nx[i] = HOLD_LOAD;
         end else if (state[i] == HOLD) begin
            if (hold_cnt[i] == '0)
               state_nx[i] = vsd_sel_r[i] ? READY : EMPTY;
            else
               hold_cnt_nx[i] = hold_cnt[i] - HW'(1);
         end
      end
   end

   // Outputs: reset request is registered from the next state so it tracks HOLD without lag.
   always_comb begin
      reset_img_nx = 1'b0;
      for (int i = 0; i < NUM_DRIVES; i++)
         if (state_nx[i] == HOLD) reset_img_nx = 1'b1;
   end

   assign spi_edge = (old_mosi ^ bus.sd_mosi) | (old_miso ^ bus.sd_miso);
   assign hit      = {NUM_DRIVES{spi_edge}} & ~bus.sd_cs_n & vsd_sel_r;

   // Previous SPI line levels for edge detection.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         old_mosi <= 1'b0;
         old_miso <= 1'b0;
      end else begin
         old_mosi <= bus.sd_mosi;
         old_miso <= bus.sd_miso;
      end
   end

   // Per-drive idle counters: cleared by an attributed edge, saturate at the timeout.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DRIVES; i++) act_cnt[i] <= ACT_MAX;
      end else begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            if (hit[i])
               act_cnt[i] <= '0;
            else if (act_cnt[i] < ACT_MAX)
               act_cnt[i] <= act_cnt[i] + AW'(1);
         end
      end
   end

   always_comb begin
      active = '0;
      for (int i = 0; i < NUM_DRIVES; i++) active[i] = (act_cnt[i] != ACT_MAX);
   end

   // Free-running blink phase and registered LED; a download forces the LED solid on.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         led_n_r   <= 1'b1;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
         led_n_r   <= ~(bus.ioctl_download |
                        ((|active) & (~bus.blink_en | ~blink_cnt[BLINK_W-1])));
      end
   end

   assign bus.vsd_sel      = vsd_sel_r;
   assign bus.ss_gated     = bus.sd_cs_n | ~vsd_sel_r;
   assign bus.drive_active = active;
   assign bus.reset_img    = reset_img_r;
   assign bus.led_n        = led_n_r;
endmodule

// File: tb/tb_sd_mount_ctrl.sv
// tb/tb_sd_mount_ctrl.sv - directed self-checking bench for sd_mount_ctrl
module tb_sd_mount_ctrl;
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   sd_mount_ctrl_if #(.NUM_DRIVES(2)) bus ();

   sd_mount_ctrl #(
      .NUM_DRIVES (2),
      .RESET_HOLD (8),
      .ACT_TIMEOUT(5),
      .BLINK_W    (3)
   ) dut (
      .clk_sys(clk_sys),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input logic [1:0] drv, input logic [1:0] nz);
      bus.img_mounted = drv;
      bus.img_size_nz = nz;
      tick();
      bus.img_mounted = 2'b00;
   endtask

   task automatic test_reset();
      bus.img_mounted = 2'b00; bus.img_size_nz = 2'b00; bus.sd_cs_n = 2'b00;
      bus.sd_mosi = 1'b0; bus.sd_miso = 1'b0; bus.ioctl_download = 1'b0; bus.blink_en = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (bus.vsd_sel !== 2'b00) begin errors++; $display("FAIL reset_vsd_sel: got %b expected 00", bus.vsd_sel); end
      checks++; if (bus.reset_img !== 1'b0) begin errors++; $display("FAIL reset_reset_img: got %b expected 0", bus.reset_img); end
      checks++; if (bus.drive_active !== 2'b00) begin errors++; $display("FAIL reset_active: got %b expected 00", bus.drive_active); end
      checks++; if (bus.led_n !== 1'b1) begin errors++; $display("FAIL reset_led_n: got %b expected 1", bus.led_n); end
      checks++; if (bus.ss_gated !== 2'b11) begin errors++; $display("FAIL reset_ss_gated: got %b expected 11", bus.ss_gated); end
      reset = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_mount();
      logic exp;
      strobe(2'b01, 2'b01);
      checks++; if (bus.vsd_sel !== 2'b01) begin errors++; $display("FAIL mount_vsd_sel: got %b expected 01", bus.vsd_sel); end
      checks++; if (bus.ss_gated !== 2'b10) begin errors++; $display("FAIL mount_ss_gated_00: got %b expected 10", bus.ss_gated); end
      bus.sd_cs_n = 2'b01; #1;
      checks++; if (bus.ss_gated !== 2'b11) begin errors++; $display("FAIL mount_ss_gated_01: got %b expected 11", bus.ss_gated); end
      bus.sd_cs_n = 2'b00;
      for (int k = 1; k <= 10; k++) begin
         exp = (k <= 8);
         checks++;
         if (bus.reset_img !== exp) begin
            errors++; $display("FAIL mount_reset_img cycle +%0d: got %b expected %b", k, bus.reset_img, exp);
         end
         tick();
      end
   endtask

   task automatic test_eject_remount();
      logic exp;
      bus.img_mounted = 2'b01; bus.img_size_nz = 2'b00;
      tick();
      bus.img_mounted = 2'b00;
      checks++; if (bus.vsd_sel !== 2'b00) begin errors++; $display("FAIL eject_vsd_sel: got %b expected 00", bus.vsd_sel); end
      for (int k = 1; k <= 14; k++) begin
         exp = (k <= 12);
         checks++;
         if (bus.reset_img !== exp) begin
            errors++; $display("FAIL eject_remount_reset_img cycle +%0d: got %b expected %b", k, bus.reset_img, exp);
         end
         if (k == 4) begin bus.img_mounted = 2'b10; bus.img_size_nz = 2'b10; end
         tick();
         bus.img_mounted = 2'b00;
      end
      checks++; if (bus.vsd_sel !== 2'b10) begin errors++; $display("FAIL remount_vsd_sel: got %b expected 10", bus.vsd_sel); end
   endtask

   task automatic test_activity();
      logic [1:0] exp_act;
      logic       exp_led;
      strobe(2'b01, 2'b01);
      repeat (10) tick();
      bus.sd_cs_n = 2'b10; #1;
      checks++; if (bus.drive_active !== 2'b00) begin errors++; $display("FAIL act_idle: got %b expected 00", bus.drive_active); end
      bus.sd_mosi = ~bus.sd_mosi;
      tick();
      for (int k = 1; k <= 8; k++) begin
         exp_act = (k <= 5) ? 2'b01 : 2'b00;
         exp_led = (k >= 2 && k <= 6) ? 1'b0 : 1'b1;
         checks++;
         if (bus.drive_active !== exp_act) begin
            errors++; $display("FAIL act_drive_active cycle +%0d: got %b expected %b", k, bus.drive_active, exp_act);
         end
         checks++;
         if (bus.led_n !== exp_led) begin
            errors++; $display("FAIL act_led_n cycle +%0d: got %b expected %b", k, bus.led_n, exp_led);
         end
         tick();
      end
   endtask

   task automatic test_unmounted();
      strobe(2'b10, 2'b00);
      repeat (10) tick();
      checks++; if (bus.vsd_sel !== 2'b01) begin errors++; $display("FAIL unmount_vsd_sel: got %b expected 01", bus.vsd_sel); end
      bus.sd_cs_n = 2'b01;
      for (int k = 0; k < 10; k++) begin
         bus.sd_miso = ~bus.sd_miso;
         tick();
         checks++;
         if (bus.drive_active !== 2'b00 || bus.led_n !== 1'b1) begin
            errors++; $display("FAIL unmounted_ignored cycle %0d: got active=%b led_n=%b expected active=00 led_n=1", k, bus.drive_active, bus.led_n);
         end
      end
   endtask

   task automatic test_blink();
      logic s [28];
      int   j;
      int   lows;
      bus.sd_cs_n  = 2'b10;
      bus.blink_en = 1'b1;
      for (int k = 0; k < 28; k++) begin
         if (k % 2 == 0) bus.sd_mosi = ~bus.sd_mosi;
         tick();
         s[k] = bus.led_n;
      end
      j = -1;
      for (int k = 10; k >= 7; k--) if (s[k] !== s[k-1]) j = k;
      checks++;
      if (j < 0) begin
         errors++; $display("FAIL blink_transition: got no led_n change in 4 cycles expected one");
      end else begin
         lows = 0;
         for (int m = 1; m <= 16; m++) begin
            checks++;
            if ((m % 4 == 0) ? (s[j+m] === s[j+m-1]) : (s[j+m] !== s[j+m-1])) begin
               errors++; $display("FAIL blink_pattern offset %0d: got %b after %b expected %s", m, s[j+m], s[j+m-1], (m % 4 == 0) ? "toggle" : "hold");
            end
         end
         for (int m = 0; m < 16; m++) if (s[j+m] === 1'b0) lows++;
         checks++;
         if (lows != 8) begin errors++; $display("FAIL blink_duty: got %0d low of 16 expected 8", lows); end
      end
      bus.ioctl_download = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.led_n !== 1'b0) begin
            errors++; $display("FAIL download_led_n cycle %0d: got %b expected 0", k, bus.led_n);
         end
         tick();
      end
      bus.ioctl_download = 1'b0;
      bus.blink_en = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_hold();
      bus.ioctl_download = 1'b1;
      tick();
      strobe(2'b01, 2'b01);
      repeat (2) tick();
      checks++; if (bus.reset_img !== 1'b1 || bus.led_n !== 1'b0) begin errors++; $display("FAIL midhold_pre: got reset_img=%b led_n=%b expected 1 0", bus.reset_img, bus.led_n); end
      #1 reset = 1'b1;
      #1;
      checks++; if (bus.reset_img !== 1'b0) begin errors++; $display("FAIL midhold_reset_img: got %b expected 0", bus.reset_img); end
      checks++; if (bus.vsd_sel !== 2'b00) begin errors++; $display("FAIL midhold_vsd_sel: got %b expected 00", bus.vsd_sel); end
      checks++; if (bus.led_n !== 1'b1) begin errors++; $display("FAIL midhold_led_n: got %b expected 1", bus.led_n); end
      tick();
      reset = 1'b0;
      bus.ioctl_download = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (bus.reset_img !== 1'b0) begin
            errors++; $display("FAIL post_reset_reset_img cycle %0d: got %b expected 0", k, bus.reset_img);
         end
      end
      checks++; if (bus.vsd_sel !== 2'b00) begin errors++; $display("FAIL post_reset_vsd_sel: got %b expected 00", bus.vsd_sel); end
   endtask

   initial begin
      test_reset();
      test_mount();
      test_eject_remount();
      test_activity();
      test_unmounted();
      test_blink();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sd_mount_ctrl.md
Name: sd_mount_ctrl

Overview:
- Multi-drive virtual-SD mount and activity controller. It sits between the mist_io image/mount signals and the core's SPI SD interface.
- Per drive, it tracks whether an image is mounted and gates that drive's chip select.
- Any mount or eject produces a fixed-length core reset pulse.
- SPI activity is measured per drive, with a timeout, and drives the board activity LED. Blink mode is optional.

Parameters:
- NUM_DRIVES, 2, number of virtual SD drives (1..8).
- RESET_HOLD, 10000000, length in clk_sys cycles of reset_img after a mount event (>=1).
- ACT_TIMEOUT, 1000000, cycles a drive stays active after its last SPI edge (>=1).
- BLINK_W, 22, width of the blink phase counter; LED period is 2^BLINK_W cycles.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- img_mounted  in  NUM_DRIVES  one-cycle mount/eject strobe per drive.
- img_size_nz  in  NUM_DRIVES  image size non-zero, valid with img_mounted.
- sd_cs_n  in  NUM_DRIVES  core chip select per drive, active low.
- sd_mosi  in  1  shared SPI MOSI from the core.
- sd_miso  in  1  shared SPI MISO toward the core.
- ioctl_download  in  1  ROM download in progress.
- blink_en  in  1  1 = activity shown as blinking, 0 = solid.
- vsd_sel  out  NUM_DRIVES  drive has an image.
- ss_gated  out  NUM_DRIVES  sd_cs_n[i] | ~vsd_sel[i]; combinational from inputs and registers.
- drive_active  out  NUM_DRIVES  per-drive activity flag.
- reset_img  out  1  core cold-reset request.
- led_n  out  1  activity LED, active low.

Behaviour:
Reset values:
- vsd_sel=0, state=EMPTY, reset_img=0, activity counters=ACT_TIMEOUT (inactive), edge registers=0, blink counter=0, led_n=1.

Per-drive mount FSM (EMPTY, HOLD, READY):
- Any state, img_mounted[i]=1 at cycle t:
  - vsd_sel[i] <= img_size_nz[i].
  - State goes to HOLD and the hold counter loads RESET_HOLD-1.
- HOLD:
  - Counter decrements each cycle.
  - At 0, the next state is READY if vsd_sel[i]=1, otherwise EMPTY.
- A strobe during HOLD restarts the counter. Strobes on different drives in the same cycle are handled independently.
- reset_img is registered and equals the OR of (state==HOLD) over all drives. It is high for cycles t+1 .. t+RESET_HOLD after the last strobe, with no gap when HOLD windows overlap.
- An eject (img_size_nz=0) still produces the full reset pulse.

Activity detection:
- old_mosi and old_miso are registered every cycle.
- An edge is (old_mosi^sd_mosi)|(old_miso^sd_miso).
- The edge is attributed to drive i if sd_cs_n[i]=0 and vsd_sel[i]=1 in the edge cycle. Several drives may take the same edge.
- Per-drive counter of width clog2(ACT_TIMEOUT+1):
  - An attributed edge clears it to 0.
  - Otherwise it increments while below ACT_TIMEOUT and saturates at ACT_TIMEOUT.
- drive_active[i] = (cnt[i] != ACT_TIMEOUT). For an edge at cycle t, it is high for cycles t+1 .. t+ACT_TIMEOUT.
- A new edge while active restarts the window.
- vsd_sel[i] falling does not clear a running counter.

LED:
- The blink counter is BLINK_W bits, free-running and wraps. blink_phase = ~blink_cnt[BLINK_W-1].
- led_n is registered: led_n <= ~(ioctl_download | (|drive_active & (~blink_en | blink_phase))).
- This gives one cycle of latency after drive_active.
- ioctl_download overrides blink, so the LED is solid on during a download.

Reset mid-operation:
- Asserting reset during HOLD drops reset_img asynchronously.
- All drives return to EMPTY, and previously mounted images are forgotten.

Test Plan:
Benches use NUM_DRIVES=2, RESET_HOLD=8, ACT_TIMEOUT=5, BLINK_W=3.
1. Mount: release reset; pulse img_mounted=01, img_size_nz=01 at cycle 10 -> vsd_sel=01 from cycle 11; reset_img high cycles 11..18 exactly; drive 0 state READY at cycle 19; ss_gated[1]=1 regardless of sd_cs_n[1].
2. Eject and remount: eject drive 0 (img_size_nz=0) at cycle 30, then remount drive 1 at cycle 34 -> reset_img high continuously cycles 31..42; vsd_sel=10 afterwards.
3. Activity: with drive 0 mounted and sd_cs_n=10, toggle sd_mosi once at cycle 50 -> drive_active=01 cycles 51..55, led_n low cycles 52..56, otherwise 1; drive 1 stays inactive.
4. Unmounted drive ignored: with drive 1 unmounted, sd_cs_n=01 and sd_miso toggled every cycle -> drive_active stays 00 and led_n stays 1.
5. Blink: blink_en=1, sd_mosi toggled every 2 cycles on drive 0 -> led_n low 4 cycles, high 4 cycles, repeating; raising ioctl_download forces led_n=0 one cycle later.
6. Reset mid-HOLD: assert reset 3 cycles into HOLD -> reset_img=0, vsd_sel=00, led_n=1 immediately; after release, no reset_img pulse occurs without a new strobe.
